// File: rtl/pc_ret_stack.sv
// pc_ret_stack: program counter sequencer with a hardware return-address stack
module pc_ret_stack #(
  parameter int ADDR_W = 16,
  parameter int DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       pcflag,
  input  logic                       fcall,
  input  logic                       fcallend,
  input  logic [ADDR_W-1:0]          target,
  output logic [ADDR_W-1:0]          pc,
  output logic                       redirect,
  output logic [$clog2(DEPTH):0]     depth,
  output logic                       stack_full,
  output logic                       stack_empty,
  output logic                       ovf_err,
  output logic                       unf_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;
  logic [ADDR_W-1:0] stack [DEPTH];
  logic [ADDR_W-1:0] pc_inc, top;
  logic [DW-1:0] depth_m1;
  logic do_call, do_ret, do_br;
  assign stack_full = depth == DW'(DEPTH);
  assign stack_empty = depth == '0;
  assign pc_inc = pc + ADDR_W'(1);
  assign depth_m1 = depth - DW'(1);
  assign top = stack[depth_m1[AW-1:0]];
  assign do_call = fcall & ~stack_full;
  assign do_ret = ~fcall & fcallend & ~stack_empty;
  assign do_br = ~fcall & ~fcallend & pcflag;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
      depth <= '0;
      redirect <= 1'b0;
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else if (en) begin
      pc <= (do_call | do_br) ? target : do_ret ? top : pc_inc;
      depth <= do_call ? depth + DW'(1) : do_ret ? depth_m1 : depth;
      redirect <= do_call | do_ret | do_br;
      ovf_err <= ovf_err | (fcall & stack_full);
      unf_err <= unf_err | (~fcall & fcallend & stack_empty);
    end else begin
      redirect <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (en & do_call) stack[depth[AW-1:0]] <= pc_inc;
  end
endmodule

// File: tb/tb_pc_ret_stack.sv
// tb_pc_ret_stack: randomized scoreboard bench against a queue-based reference model
module tb_pc_ret_stack;
  localparam int DEPTH = 8;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, pcflag = 1'b0, fcall = 1'b0, fcallend = 1'b0;
  logic [15:0] target = '0;
  logic [15:0] pc;
  logic redirect, stack_full, stack_empty, ovf_err, unf_err;
  logic [3:0] depth;
  typedef struct {
    logic [15:0] pc;
    logic red;
    int dep;
    logic ovf;
    logic unf;
  } exp_t;
  exp_t exp_q[$];
  logic [15:0] m_stack[$];
  logic [15:0] m_pc;
  logic m_red, m_ovf, m_unf;
  int errors = 0, checks = 0;
  pc_ret_stack #(.ADDR_W(16), .DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pcflag(pcflag), .fcall(fcall), .fcallend(fcallend),
    .target(target), .pc(pc), .redirect(redirect), .depth(depth), .stack_full(stack_full),
    .stack_empty(stack_empty), .ovf_err(ovf_err), .unf_err(unf_err)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask
  task automatic chk_all(exp_t e);
    chk("pc", int'(pc), int'(e.pc));
    chk("redirect", int'(redirect), int'(e.red));
    chk("depth", int'(depth), e.dep);
    chk("stack_full", int'(stack_full), int'(e.dep == DEPTH));
    chk("stack_empty", int'(stack_empty), int'(e.dep == 0));
    chk("ovf_err", int'(ovf_err), int'(e.ovf));
    chk("unf_err", int'(unf_err), int'(e.unf));
  endtask
  function automatic exp_t snap();
    exp_t e;
    e.pc = m_pc; e.red = m_red; e.dep = m_stack.size(); e.ovf = m_ovf; e.unf = m_unf;
    return e;
  endfunction
  task automatic model_reset();
    m_stack.delete();
    m_pc = 16'h0000; m_red = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
  endtask
  task automatic drive(bit e, bit fc, bit fe, bit pf, logic [15:0] t);
    en = e; fcall = fc; fcallend = fe; pcflag = pf; target = t;
    m_red = 1'b0;
    if (e) begin
      if (fc) begin
        if (m_stack.size() < DEPTH) begin
          m_stack.push_back(m_pc + 16'd1);
          m_pc = t; m_red = 1'b1;
        end else begin
          m_pc = m_pc + 16'd1; m_ovf = 1'b1;
        end
      end else if (fe) begin
        if (m_stack.size() > 0) begin
          m_pc = m_stack.pop_back(); m_red = 1'b1;
        end else begin
          m_pc = m_pc + 16'd1; m_unf = 1'b1;
        end
      end else if (pf) begin
        m_pc = t; m_red = 1'b1;
      end else begin
        m_pc = m_pc + 16'd1;
      end
    end
    exp_q.push_back(snap());
  endtask
  task automatic step(bit e, bit fc, bit fe, bit pf, logic [15:0] t);
    @(negedge clk);
    drive(e, fc, fe, pf, t);
  endtask
  task automatic mid_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_pc", int'(pc), 0);
    chk("async_rst_depth", int'(depth), 0);
    chk("async_rst_redirect", int'(redirect), 0);
    #1 rst_n = 1'b1;
    drive(0, 0, 0, 0, 16'h0);
  endtask
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) chk_all(exp_q.pop_front());
    end
  end
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 chk_all(snap());
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 0, 0, 16'h0);
    repeat (3) step(1, 0, 0, 0, 16'h0);
    step(1, 0, 0, 1, 16'h0010);
    step(1, 0, 0, 1, 16'h0040);
    step(1, 0, 0, 0, 16'h0);
    step(1, 0, 0, 1, 16'h0005);
    step(1, 1, 0, 0, 16'h0100);
    repeat (2) step(1, 0, 0, 0, 16'h0);
    step(1, 1, 0, 0, 16'h0200);
    step(1, 0, 1, 0, 16'h0);
    step(1, 0, 1, 0, 16'h0);
    for (int i = 0; i < 9; i++) step(1, 1, 0, 0, 16'h1000 + 16'(i * 16));
    for (int i = 0; i < 9; i++) step(1, 0, 1, 0, 16'h0);
    step(1, 0, 0, 1, 16'hFFFF);
    step(1, 1, 0, 1, 16'h0300);
    step(1, 0, 1, 1, 16'h0777);
    step(1, 1, 1, 0, 16'h0400);
    step(1, 0, 0, 1, 16'h0402);
    repeat (3) step(0, 1, 0, 0, 16'h0500);
    repeat (2) step(1, 1, 0, 0, 16'h0600);
    mid_reset();
    for (int i = 0; i < 600; i++) begin
      automatic int r = $urandom_range(0, 99);
      if (r < 2) mid_reset();
      else step($urandom_range(0, 9) != 0, r < 35, $urandom_range(0, 2) == 0,
                $urandom_range(0, 3) == 0, 16'($urandom));
    end
    step(0, 0, 0, 0, 16'h0);
    repeat (2) @(posedge clk);
    #2 chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pc_ret_stack.md
Name: pc_ret_stack

Overview:
- Program-counter sequencer that consumes the branch unit's decision outputs: pcflag (conditional branch taken), fcall (function call) and fcallend (function return).
- Holds the PC and a hardware return-address LIFO.
- Each enabled cycle it selects the next PC: sequential, branch target, call target, or popped return address.
- Raises a redirect pulse so the fetch stage can squash the wrong-path instruction.

Parameters:
- ADDR_W, 16, PC and target width.
- DEPTH, 8, return-stack entries; must be a power of two ≥2.
- RESET_PC, 16'h0000, PC value after reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  advance enable; low = stall, all state held.
- pcflag  input  1  conditional branch taken, from branch unit.
- fcall  input  1  call request, from branch unit.
- fcallend  input  1  return request, from branch unit.
- target  input  ADDR_W  branch/call destination for the current instruction.
- pc  output  ADDR_W  current program counter.
- redirect  output  1  registered; high for exactly one cycle after a cycle in which PC was loaded non-sequentially.
- depth  output  $clog2(DEPTH)+1  number of valid stack entries.
- stack_full  output  1  depth == DEPTH (combinational from depth).
- stack_empty  output  1  depth == 0 (combinational from depth).
- ovf_err  output  1  sticky: call attempted while full.
- unf_err  output  1  sticky: return attempted while empty.

Behaviour:
- Reset (async assert, sync-free deassert):
  - pc = RESET_PC, depth = 0, redirect = 0, ovf_err = 0, unf_err = 0.
  - Stack contents don't-care.
  - Reset mid-operation discards all stacked return addresses immediately.
- en = 0: pc, depth, stack and error flags hold; redirect goes to 0 next edge.
- en = 1: exactly one action per cycle, priority fcall > fcallend > pcflag > sequential.
  - CALL (fcall, not full):
    - stack[depth] <= pc + 1, depth <= depth + 1, pc <= target, redirect <= 1.
  - CALL while full:
    - No push, depth unchanged, pc <= pc + 1, ovf_err <= 1, redirect <= 0.
    - The call is dropped; the PC falls through.
  - RETURN (fcallend, not empty):
    - pc <= stack[depth-1], depth <= depth - 1, redirect <= 1.
  - RETURN while empty:
    - pc <= pc + 1, depth stays 0, unf_err <= 1, redirect <= 0.
  - BRANCH (pcflag, no call/return): pc <= target, redirect <= 1.
    - redirect is set even if target == pc + 1.
  - SEQUENTIAL: pc <= pc + 1, redirect <= 0.
- Arithmetic: pc + 1 is modulo 2^ADDR_W; 16'hFFFF increments to 16'h0000, and that return address is stored as 16'h0000.
- Simultaneous inputs: fcall with pcflag means call; fcallend with pcflag means return; fcall with fcallend means call only.
- Latency: next-PC decision takes effect on the edge after the inputs; redirect aligns with the first cycle the new pc is visible.
- Error flags clear only on reset.
- Stack storage is registers; read of the top entry is combinational.

Test Plan:
- Reset and sequential step: release rst_n with en = 1 and no requests for 4 cycles → pc = 0,1,2,3,4; redirect = 0; depth = 0; stack_empty = 1.
- Branch: pc = 0x0010, pcflag = 1, target = 0x0040 → next pc = 0x0040, redirect = 1 for one cycle, depth unchanged; then pc = 0x0041.
- Nested call and return:
  - At pc = 0x0005, call to 0x0100; at pc = 0x0102, call to 0x0200.
  - Two returns → pc = 0x0103, then 0x0006; depth 1→2→1→0.
  - redirect pulses on each of the four events.
- Overflow/underflow (DEPTH = 8):
  - 8 calls → stack_full = 1; a 9th call → pc = old pc + 1, depth = 8, ovf_err = 1.
  - Drain 8 returns; a 9th return → pc + 1, unf_err = 1, depth = 0.
- Priority and wrap:
  - pc = 0xFFFF with fcall = pcflag = 1, target = 0x0300 → pc = 0x0300, stacked return = 0x0000.
  - Subsequent return → pc = 0x0000.
- Stall and async reset:
  - Hold en = 0 for 3 cycles with fcall = 1 → pc/depth unchanged, redirect = 0.
  - Assert rst_n = 0 mid-cycle with depth = 3 → pc = RESET_PC and depth = 0 immediately, without waiting for a clock edge.
